// File: rtl/el2_ifu_pkg.sv
// Shared IFU definitions: fetch-buffer geometry defaults and the buffered entry layout.
package el2_ifu_pkg;

  localparam int unsigned FB_DEPTH_DEF = 4;
  localparam int unsigned FB_DW_DEF    = 32;

  typedef struct packed {
    logic [FB_DW_DEF-1:0] data;
    logic [30:0]          pc;
    logic                 fault;
  } fb_entry_t;

endpackage

// File: rtl/el2_ifu_fb_entry.sv
// One fetch-buffer slot: enabled flop with no reset, contents only change on write select.
module el2_ifu_fb_entry
  import el2_ifu_pkg::*;
#(
  parameter type entry_t = fb_entry_t
) (
  input  logic   clk,
  input  logic   en,
  input  entry_t din,
  output entry_t dout
);

  always_ff @(posedge clk) begin
    if (en) dout <= din;
  end

endmodule

// File: rtl/el2_ifu_fb_ctl.sv
// IFU fetch buffer: circular FIFO between fetch return and the aligner, up to 2 reads per cycle.
module el2_ifu_fb_ctl
  import el2_ifu_pkg::*;
#(
  parameter int unsigned FB_DEPTH = FB_DEPTH_DEF,
  parameter int unsigned FB_DW    = FB_DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_valid,
  input  logic [FB_DW-1:0] wr_data,
  input  logic [30:0]      wr_pc,
  input  logic             wr_fault,
  output logic [1:0]       rd_valid,
  output logic [FB_DW-1:0] rd_data0,
  output logic [FB_DW-1:0] rd_data1,
  output logic [30:0]      rd_pc0,
  output logic [30:0]      rd_pc1,
  output logic [1:0]       rd_fault,
  input  logic [1:0]       aln_consume,
  output logic             ifu_fb_consume1,
  output logic             ifu_fb_consume2,
  output logic             fb_full,
  output logic             fb_empty,
  output logic             fb_overflow
);

  localparam int unsigned PW = $clog2(FB_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Same layout as fb_entry_t, resized to this instance's data width.
  typedef struct packed {
    logic [FB_DW-1:0] data;
    logic [30:0]      pc;
    logic             fault;
  } entry_t;

  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr1;
  logic [CW-1:0] count, count_nxt;
  logic [1:0]    req_consume, eff_consume;
  logic          room, wr_try, wr_en;
  entry_t        wr_entry;
  entry_t        entry_q [FB_DEPTH];

  always_comb begin
    req_consume = (aln_consume == 2'd3) ? 2'd2 : aln_consume;
    eff_consume = req_consume;
    if (count < CW'(req_consume)) eff_consume = count[1:0];
  end

  // Room is judged after this cycle's retirement, so a full buffer still accepts
  // a write when the aligner drains at least one entry in the same cycle.
  assign room      = (count - CW'(eff_consume)) < CW'(FB_DEPTH);
  assign wr_try    = wr_valid & ~flush & ~rst;
  assign wr_en     = wr_try & room;
  assign count_nxt = count + CW'(wr_en) - CW'(eff_consume);

  assign ifu_fb_consume1 = (eff_consume == 2'd1) & ~flush & ~rst;
  assign ifu_fb_consume2 = (eff_consume == 2'd2) & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fb_full     <= 1'b0;
      fb_empty    <= 1'b1;
      fb_overflow <= 1'b0;
    end else if (flush) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fb_full  <= 1'b0;
      fb_empty <= 1'b1;
    end else begin
      count    <= count_nxt;
      rd_ptr   <= rd_ptr + PW'(eff_consume);
      fb_full  <= (count_nxt == CW'(FB_DEPTH));
      fb_empty <= (count_nxt == '0);
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (wr_try && !room) fb_overflow <= 1'b1;
    end
  end

  assign wr_entry = '{data: wr_data, pc: wr_pc, fault: wr_fault};

  for (genvar i = 0; i < FB_DEPTH; i++) begin : g_entry
    el2_ifu_fb_entry #(
      .entry_t(entry_t)
    ) u_entry (
      .clk  (clk),
      .en   (wr_en && (wr_ptr == PW'(i))),
      .din  (wr_entry),
      .dout (entry_q[i])
    );
  end

  assign rd_ptr1  = rd_ptr + PW'(1);
  assign rd_valid = {(count >= CW'(2)), (count != '0)};
  assign rd_data0 = entry_q[rd_ptr].data;
  assign rd_data1 = entry_q[rd_ptr1].data;
  assign rd_pc0   = entry_q[rd_ptr].pc;
  assign rd_pc1   = entry_q[rd_ptr1].pc;
  assign rd_fault = {entry_q[rd_ptr1].fault, entry_q[rd_ptr].fault};

endmodule

// File: tb/tb_el2_ifu_fb_ctl.sv
// Bench for el2_ifu_fb_ctl: directed table, corner sequences and a queue-based random model.
module tb_el2_ifu_fb_ctl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst, flush, wr_valid, wr_fault;
  logic [DW-1:0] wr_data;
  logic [30:0]   wr_pc;
  logic [1:0]    rd_valid, rd_fault, aln_consume;
  logic [DW-1:0] rd_data0, rd_data1;
  logic [30:0]   rd_pc0, rd_pc1;
  logic          ifu_fb_consume1, ifu_fb_consume2, fb_full, fb_empty, fb_overflow;

  el2_ifu_fb_ctl #(
    .FB_DEPTH(DEPTH),
    .FB_DW   (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_pc          (wr_pc),
    .wr_fault       (wr_fault),
    .rd_valid       (rd_valid),
    .rd_data0       (rd_data0),
    .rd_data1       (rd_data1),
    .rd_pc0         (rd_pc0),
    .rd_pc1         (rd_pc1),
    .rd_fault       (rd_fault),
    .aln_consume    (aln_consume),
    .ifu_fb_consume1(ifu_fb_consume1),
    .ifu_fb_consume2(ifu_fb_consume2),
    .fb_full        (fb_full),
    .fb_empty       (fb_empty),
    .fb_overflow    (fb_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [30:0]   pc;
    logic          fault;
  } rec_t;

  typedef struct {
    bit          rst, flush, wv;
    logic [30:0] pc;
    logic [1:0]  aln;
    bit          c1, c2;
    logic [1:0]  rdv;
    bit          full, empty, ovf;
    logic [1:0]  chk;
    logic [30:0] pc0, pc1;
  } vec_t;

  rec_t mq[$];
  bit   m_ovf;
  int   m_eff;
  int   n_cmp, n_bad;
  vec_t tbl[12];

  function automatic logic [DW-1:0] dat(input logic [30:0] p);
    return {1'b1, p};
  endfunction

  function automatic vec_t mk(bit r, bit f, bit wv, logic [30:0] p, logic [1:0] a,
                              bit c1, bit c2, logic [1:0] rdv, bit full, bit empty,
                              bit ovf, logic [1:0] chk, logic [30:0] p0, logic [30:0] p1);
    vec_t v;
    v.rst = r; v.flush = f; v.wv = wv; v.pc = p; v.aln = a;
    v.c1 = c1; v.c2 = c2; v.rdv = rdv; v.full = full; v.empty = empty; v.ovf = ovf;
    v.chk = chk; v.pc0 = p0; v.pc1 = p1;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and compare the pre-edge outputs with the queue model.
  task automatic apply(input bit r, input bit f, input bit wv, input logic [DW-1:0] d,
                       input logic [30:0] p, input bit flt, input logic [1:0] a);
    int sz, sat;
    @(negedge clk);
    rst = r; flush = f; wr_valid = wv; wr_data = d; wr_pc = p; wr_fault = flt; aln_consume = a;
    #1;
    sz  = mq.size();
    sat = (a == 2'd3) ? 2 : int'(a);
    m_eff = (r || f) ? 0 : ((sat < sz) ? sat : sz);
    check("rd_valid", rd_valid, (sz == 0) ? 0 : (sz == 1) ? 1 : 3);
    check("fb_empty", fb_empty, sz == 0);
    check("fb_full", fb_full, sz == DEPTH);
    check("fb_overflow", fb_overflow, m_ovf);
    check("consume1", ifu_fb_consume1, m_eff == 1);
    check("consume2", ifu_fb_consume2, m_eff == 2);
    if (sz >= 1) begin
      check("rd_pc0", rd_pc0, mq[0].pc);
      check("rd_data0", rd_data0, mq[0].data);
      check("rd_fault0", rd_fault[0], mq[0].fault);
    end
    if (sz >= 2) begin
      check("rd_pc1", rd_pc1, mq[1].pc);
      check("rd_data1", rd_data1, mq[1].data);
      check("rd_fault1", rd_fault[1], mq[1].fault);
    end
  endtask

  task automatic tick();
    rec_t e;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      repeat (m_eff) void'(mq.pop_front());
      if (wr_valid) begin
        if (mq.size() < DEPTH) begin
          e.data = wr_data; e.pc = wr_pc; e.fault = wr_fault;
          mq.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit wv, input logic [30:0] p, input logic [1:0] a);
    apply(1'b0, 1'b0, wv, dat(p), p, 1'b0, a);
    tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; m_ovf = 1'b0; m_eff = 0;
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_pc = '0;
    wr_fault = 1'b0; aln_consume = 2'd0;
    repeat (2) @(posedge clk);

    // Fill, overflow, simultaneous write+consume, saturated/limited consume, reset.
    tbl[0]  = mk(0,0,1,31'h100,0, 0,0,2'b00,0,1,0,2'b00,0,0);
    tbl[1]  = mk(0,0,1,31'h102,0, 0,0,2'b01,0,0,0,2'b01,31'h100,0);
    tbl[2]  = mk(0,0,1,31'h104,0, 0,0,2'b11,0,0,0,2'b11,31'h100,31'h102);
    tbl[3]  = mk(0,0,1,31'h106,0, 0,0,2'b11,0,0,0,2'b11,31'h100,31'h102);
    tbl[4]  = mk(0,0,1,31'h108,0, 0,0,2'b11,1,0,0,2'b11,31'h100,31'h102);
    tbl[5]  = mk(0,0,1,31'h108,2, 0,1,2'b11,1,0,1,2'b11,31'h100,31'h102);
    tbl[6]  = mk(0,0,0,31'h000,0, 0,0,2'b11,0,0,1,2'b11,31'h104,31'h106);
    tbl[7]  = mk(0,0,0,31'h000,3, 0,1,2'b11,0,0,1,2'b11,31'h104,31'h106);
    tbl[8]  = mk(0,0,0,31'h000,2, 1,0,2'b01,0,0,1,2'b01,31'h108,0);
    tbl[9]  = mk(0,0,0,31'h000,1, 0,0,2'b00,0,1,1,2'b00,0,0);
    tbl[10] = mk(1,0,1,31'h0AA,2, 0,0,2'b00,0,1,1,2'b00,0,0);
    tbl[11] = mk(0,0,0,31'h000,0, 0,0,2'b00,0,1,0,2'b00,0,0);
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].rst, tbl[i].flush, tbl[i].wv, dat(tbl[i].pc), tbl[i].pc, 1'b0, tbl[i].aln);
      check("tbl_consume1", ifu_fb_consume1, tbl[i].c1);
      check("tbl_consume2", ifu_fb_consume2, tbl[i].c2);
      check("tbl_rd_valid", rd_valid, tbl[i].rdv);
      check("tbl_full", fb_full, tbl[i].full);
      check("tbl_empty", fb_empty, tbl[i].empty);
      check("tbl_overflow", fb_overflow, tbl[i].ovf);
      if (tbl[i].chk[0]) check("tbl_pc0", rd_pc0, tbl[i].pc0);
      if (tbl[i].chk[1]) check("tbl_pc1", rd_pc1, tbl[i].pc1);
      tick();
    end

    // Wrap: six writes with one retirement per cycle, PCs emerge in write order.
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b0, 1'b1, dat(31'(32'h200 + 2 * i)), 31'(32'h200 + 2 * i), 1'b0,
            (i == 0) ? 2'd0 : 2'd1);
      if (i > 0) check("wrap_pc0", rd_pc0, 31'(32'h200 + 2 * (i - 1)));
      tick();
    end
    apply(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 2'd1);
    check("wrap_last_pc0", rd_pc0, 31'h20A);
    check("wrap_no_ovf", fb_overflow, 1'b0);
    tick();

    // Flush with a same-cycle write and consume: both ignored.
    step(1, 31'h400, 0); step(1, 31'h402, 0); step(1, 31'h404, 0);
    apply(1'b0, 1'b1, 1'b1, dat(31'h4FE), 31'h4FE, 1'b0, 2'd1);
    check("flush_c1", ifu_fb_consume1, 1'b0);
    check("flush_c2", ifu_fb_consume2, 1'b0);
    tick();
    apply(1'b0, 1'b0, 1'b1, dat(31'h406), 31'h406, 1'b0, 2'd0);
    check("flush_empty", fb_empty, 1'b1);
    check("flush_rdv", rd_valid, 2'b00);
    tick();
    apply(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
    check("flush_next_pc0", rd_pc0, 31'h406);
    tick();

    // Reset mid-traffic with overflow pending and two entries held.
    step(1, 31'h500, 0); step(1, 31'h502, 0); step(1, 31'h504, 0); step(1, 31'h506, 0);
    step(0, 31'h000, 2);
    apply(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
    check("rst_pre_rdv", rd_valid, 2'b11);
    check("rst_pre_ovf", fb_overflow, 1'b1);
    tick();
    apply(1'b0, 1'b0, 1'b1, dat(31'h600), 31'h600, 1'b1, 2'd0);
    check("rst_empty", fb_empty, 1'b1);
    check("rst_ovf", fb_overflow, 1'b0);
    tick();
    apply(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
    check("rst_next_pc0", rd_pc0, 31'h600);
    check("rst_next_fault0", rd_fault[0], 1'b1);
    tick();

    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(63) == 0), ($urandom_range(15) == 0), ($urandom_range(9) < 7),
            DW'($urandom), 31'($urandom), 1'($urandom), 2'($urandom_range(3)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/el2_ifu_fb_ctl.md
EL2_IFU_FB_CTL -- requirements
Module: el2_ifu_fb_ctl

Interface
REQ-001 SHALL have parameter FB_DEPTH, default 4, number of fetch-buffer entries (power of two, 2..8).
REQ-002 SHALL have parameter FB_DW, default 32, instruction bits per entry.
REQ-003 SHALL have port clk, input, 1, single clock for all state.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1, exu_flush_final; discards all entries.
REQ-006 SHALL have port wr_valid, input, 1, F-stage fetch returned (ifc_fetch_req_f & ic_hit_f).
REQ-007 SHALL have port wr_data, input, FB_DW, fetched instruction bits.
REQ-008 SHALL have port wr_pc, input, 31, fetch address [31:1].
REQ-009 SHALL have port wr_fault, input, 1, access fault for the fetch.
REQ-010 SHALL have port rd_valid, output, 2, bit i set when head+i entry is valid.
REQ-011 SHALL have port rd_data0 / rd_data1, output, FB_DW each, head / head+1 data.
REQ-012 SHALL have port rd_pc0 / rd_pc1, output, 31 each, head / head+1 PC.
REQ-013 SHALL have port rd_fault, output, 2, head / head+1 fault bits.
REQ-014 SHALL have port aln_consume, input, 2, entries the aligner retires this cycle (0, 1, 2).
REQ-015 SHALL have port ifu_fb_consume1 / ifu_fb_consume2, output, 1 each, retired exactly 1 / 2 entries this cycle.
REQ-016 SHALL have port fb_full, output, 1, registered; count == FB_DEPTH.
REQ-017 SHALL have port fb_empty, output, 1, registered; count == 0.
REQ-018 SHALL have port fb_overflow, output, 1, sticky error flag.

Function
REQ-019 SHALL be a circular FIFO: wr_ptr, rd_ptr of log2(FB_DEPTH) bits, wrapping modulo FB_DEPTH; count of log2(FB_DEPTH)+1 bits.
REQ-020 SHALL write wr_data/wr_pc/wr_fault at wr_ptr at the clock edge when wr_valid & ~flush & (count - eff_consume) < FB_DEPTH.
REQ-021 SHALL compute eff_consume = min(aln_consume, valid entries); aln_consume == 3 SHALL be treated as 2.
REQ-022 SHALL drive ifu_fb_consume1 = (eff_consume == 1) & ~flush and ifu_fb_consume2 = (eff_consume == 2) & ~flush, combinationally, same cycle as aln_consume.
REQ-023 SHALL advance rd_ptr by eff_consume and update count = count + write - eff_consume in one cycle; write and consume in the same cycle SHALL both take effect.
REQ-024 SHALL allow a write while full only when eff_consume >= 1 in the same cycle.
REQ-025 SHALL drop a write attempted when no room exists and set fb_overflow, cleared only by rst.
REQ-026 SHALL present rd_* outputs combinationally from storage at rd_ptr, rd_ptr+1 (wrapping); data SHALL be visible the cycle after the write (1-cycle write-to-read latency, no bypass).
REQ-027 SHALL, on flush, set count=0 and rd_ptr=wr_ptr=0 at the next edge; a same-cycle wr_valid or aln_consume SHALL be ignored.
REQ-028 SHALL drive rd_valid bits from count: 00 when 0, 01 when 1, 11 when >= 2.
REQ-029 SHALL not clear storage contents on flush or reset; only valid tracking is reset.

Reset
REQ-030 SHALL, with rst high at an edge, set count=0, pointers=0, fb_empty=1, fb_full=0, fb_overflow=0, rd_valid=00.
REQ-031 SHALL give rst priority over flush, write and consume; reset mid-traffic discards all entries.
REQ-032 SHALL hold ifu_fb_consume1/2 low while rst is high.

Structure
REQ-033 SHALL place fb_entry_t (data, pc, fault) and FB_DEPTH default in shared package el2_ifu_pkg.
REQ-034 SHALL store entries with per-entry enabled flops (rvdffe-style, enable = write select), no new sub-module besides el2_ifu_fb_entry holding one fb_entry_t.
REQ-035 SHALL be fully synchronous to clk; no latches, no gated clocks inside the block.

Verification
REQ-036 SHALL test fill: 4 writes (pc 0x100,0x102,0x104,0x106), no consume -> fb_full=1 after 4th edge, rd_pc0=0x100, rd_pc1=0x102.
REQ-037 SHALL test overflow: full, write pc 0x108 with aln_consume=0 -> write dropped, fb_overflow=1, count stays 4.
REQ-038 SHALL test simultaneous: full, write 0x108 with aln_consume=2 -> ifu_fb_consume2=1, count=3, rd_pc0=0x104.
REQ-039 SHALL test wrap: 6 writes interleaved with consume 1 each cycle -> pointers wrap, PCs read in write order, no overflow.
REQ-040 SHALL test flush: count 3, flush with wr_valid=1 and aln_consume=1 -> next cycle fb_empty=1, rd_valid=00, consume outputs 0 in flush cycle.
REQ-041 SHALL test reset mid-operation: count 2, rst high one cycle -> fb_empty=1, fb_overflow=0, subsequent write appears at rd_pc0.
